// File: rtl/num_pkg.sv
// Shared types and constants for the multiplexed 7-segment number display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package num_pkg;

   typedef enum logic {IDLE, CONV} estado_t;

   localparam int DIG_HEX    = 4;
   localparam int DIG_DEC    = 5;
   localparam int NUM_ANODOS = 8;
   localparam int BIN_W      = 16;
   localparam int BCD_W      = 4 * DIG_DEC;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] glifo(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      case (d)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         4'hF: s = SEG_F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational digit decoder: one nibble plus a blank flag to active-low segments.
module hex_a_7seg
   import num_pkg::*;
(
   input  logic [3:0] digito,
   input  logic       blank,
   output logic [6:0] segmentos
);

   assign segmentos = blank ? SEG_BLANK : glifo(digito);

endmodule

// File: rtl/num_desplegado.sv
// 8-digit multiplexed display of a 16-bit value in hex or decimal; decimal goes
// through a 16-step double-dabble conversion while the old value stays on screen.
module num_desplegado
   import num_pkg::*;
#(
   parameter int REFRESH = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] op,
   input  logic        modo,
   output logic        busy,
   output logic        listo,
   output logic [7:0]  anodos,
   output logic [6:0]  segmentos
);

   localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH - 1);

   estado_t estado, estado_sig;

   logic [BIN_W-1:0]       bin_sr;
   logic [BCD_W-1:0]       bcd;
   logic [BCD_W-1:0]       bcd_aj;
   logic [BCD_W+BIN_W-1:0] desplazado;
   logic [3:0]             paso;
   logic                   ultimo_paso;
   logic [BCD_W-1:0]       digitos;
   logic                   modo_dec;
   logic                   listo_r;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          wrap;
   logic [2:0]    msd;
   logic [3:0]    digito_sel;
   logic          blank_sel;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) estado <= IDLE;
      else        estado <= estado_sig;
   end

   assign ultimo_paso = (paso == 4'd15);

   always_comb begin
      estado_sig = estado;
      case (estado)
         IDLE: if (load && modo) estado_sig = CONV;
         CONV: if (ultimo_paso)  estado_sig = IDLE;
         default: estado_sig = IDLE;
      endcase
   end

   // Double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_aj = bcd;
      for (int i = 0; i < DIG_DEC; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign desplazado = {bcd_aj[BCD_W-2:0], bin_sr, 1'b0};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_sr   <= '0;
         bcd      <= '0;
         paso     <= '0;
         digitos  <= '0;
         modo_dec <= 1'b0;
         listo_r  <= 1'b0;
      end else begin
         listo_r <= 1'b0;
         case (estado)
            IDLE: begin
               if (load) begin
                  if (modo) begin
                     bin_sr <= op;
                     bcd    <= '0;
                     paso   <= '0;
                  end else begin
                     digitos  <= {4'h0, op};
                     modo_dec <= 1'b0;
                     listo_r  <= 1'b1;
                  end
               end
            end
            CONV: begin
               bcd    <= desplazado[BCD_W+BIN_W-1:BIN_W];
               bin_sr <= desplazado[BIN_W-1:0];
               paso   <= paso + 4'd1;
               // Only the finished result ever reaches the digit register.
               if (ultimo_paso) begin
                  digitos  <= desplazado[BCD_W+BIN_W-1:BIN_W];
                  modo_dec <= 1'b1;
                  listo_r  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (estado == CONV);
   assign listo = listo_r;

   // ---------------- scan ----------------
   assign wrap = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (wrap) begin
         cnt <= '0;
         idx <= idx + 3'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign anodos = ~(8'd1 << idx);

   // Most significant nonzero digit within the active width; 0 shows one "0".
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < DIG_DEC; i++) begin
         if ((modo_dec || i < DIG_HEX) && digitos[4*i +: 4] != 4'h0) msd = 3'(i);
      end
   end

   always_comb begin
      digito_sel = 4'h0;
      case (idx)
         3'd0: digito_sel = digitos[3:0];
         3'd1: digito_sel = digitos[7:4];
         3'd2: digito_sel = digitos[11:8];
         3'd3: digito_sel = digitos[15:12];
         3'd4: digito_sel = digitos[19:16];
         default: digito_sel = 4'h0;
      endcase
   end

   assign blank_sel = (idx > msd);

   hex_a_7seg u_dec (
      .digito    (digito_sel),
      .blank     (blank_sel),
      .segmentos (segmentos)
   );

endmodule

// File: tb/tb_num_desplegado.sv
// Directed + randomized bench for num_desplegado against an arithmetic display model.
module tb_num_desplegado;

   localparam int REFRESH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] op = '0;
   logic        modo = 1'b0;
   logic        busy, listo;
   logic [7:0]  anodos;
   logic [6:0]  segmentos;

   int checks = 0;
   int errors = 0;
   int scan_cyc = 0;   // rising edges since reset release
   int m_val = 0;      // committed value on display
   bit m_dec = 1'b0;   // committed value is decimal

   localparam logic [6:0] GL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   always #5 clk = ~clk;

   num_desplegado #(.REFRESH(REFRESH)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .op        (op),
      .modo      (modo),
      .busy      (busy),
      .listo     (listo),
      .anodos    (anodos),
      .segmentos (segmentos)
   );

   function automatic logic [6:0] exp_seg(input int pos);
      int base, nd, pw;
      base = m_dec ? 10 : 16;
      nd   = m_dec ? 5 : 4;
      pw   = 1;
      for (int k = 0; k < pos; k++) pw = pw * base;
      if (pos >= nd) return 7'b1111111;
      if (pos > 0 && m_val < pw) return 7'b1111111;
      return GL[(m_val / pw) % base];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag);
      int pos;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      pos   = (scan_cyc / REFRESH) % 8;
      e_an  = ~(8'd1 << pos);
      e_seg = exp_seg(pos);
      chk({tag, "/anodos"}, {24'd0, anodos}, {24'd0, e_an});
      chk({tag, "/seg"}, {25'd0, segmentos}, {25'd0, e_seg});
   endtask

   task automatic chk_flags(input string tag, input logic b, input logic l);
      chk({tag, "/busy"}, {31'd0, busy}, {31'd0, b});
      chk({tag, "/listo"}, {31'd0, listo}, {31'd0, l});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) scan_cyc++;
   endtask

   task automatic step(input string tag);
      tick();
      chk_disp(tag);
   endtask

   task automatic scan_all(input string tag);
      repeat (8 * REFRESH) begin
         step(tag);
         chk_flags(tag, 1'b0, 1'b0);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic md, input string tag);
      op = v; modo = md; load = 1'b1;
      if (!md) begin
         m_val = int'(v); m_dec = 1'b0;
         step(tag);
         load = 1'b0; op = 16'($urandom); modo = 1'($urandom_range(0, 1));
         chk_flags(tag, 1'b0, 1'b1);
      end else begin
         step(tag);
         load = 1'b0; op = 16'($urandom); modo = 1'($urandom_range(0, 1));
         chk_flags(tag, 1'b1, 1'b0);
         repeat (15) begin
            step(tag);
            chk_flags(tag, 1'b1, 1'b0);
         end
         m_val = int'(v); m_dec = 1'b1;
         step(tag);
         chk_flags(tag, 1'b0, 1'b1);
      end
      step(tag);
      chk_flags(tag, 1'b0, 1'b0);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      chk_flags("reset", 1'b0, 1'b0);
      chk("reset/an", {24'd0, anodos}, 32'h0000_00FE);
      chk("reset/seg", {25'd0, segmentos}, 32'h0000_0040);
      #1 reset = 1'b1;
      repeat (REFRESH) step("scan0");
      chk("scan1/an", {24'd0, anodos}, 32'h0000_00FD);
      chk("scan1/seg", {25'd0, segmentos}, 32'h0000_007F);

      do_load(16'h00A3, 1'b0, "hexA3");
      scan_all("hexA3");
      do_load(16'hFFFF, 1'b1, "decFFFF");
      scan_all("decFFFF");

      // second load during conversion is ignored
      op = 16'd1234; modo = 1'b1; load = 1'b1;
      step("ign");
      load = 1'b0;
      chk_flags("ign", 1'b1, 1'b0);
      repeat (4) begin step("ign"); chk_flags("ign", 1'b1, 1'b0); end
      op = 16'd1; modo = 1'b1; load = 1'b1;
      step("ign");
      load = 1'b0;
      chk_flags("ign", 1'b1, 1'b0);
      repeat (10) begin step("ign"); chk_flags("ign", 1'b1, 1'b0); end
      m_val = 1234; m_dec = 1'b1;
      step("ign");
      chk_flags("ign", 1'b0, 1'b1);
      scan_all("ign1234");

      // reset aborts conversion mid-way
      op = 16'd999; modo = 1'b1; load = 1'b1;
      step("abort");
      load = 1'b0;
      repeat (7) step("abort");
      reset = 1'b0;
      scan_cyc = 0; m_val = 0; m_dec = 1'b0;
      #1;
      chk_flags("abort", 1'b0, 1'b0);
      chk_disp("abort");
      tick();
      reset = 1'b1;
      do_load(16'd42, 1'b1, "dec42");
      scan_all("dec42");

      // modo/op toggles without load do nothing
      do_load(16'h00FF, 1'b0, "hexFF");
      modo = 1'b1; op = 16'h1234;
      scan_all("hold");
      modo = 1'b0; op = 16'h0000;
      scan_all("hold2");

      // boundaries
      do_load(16'h0000, 1'b0, "hex0");   scan_all("hex0");
      do_load(16'h0000, 1'b1, "dec0");   scan_all("dec0");
      do_load(16'hFFFF, 1'b0, "hexFFFF"); scan_all("hexFFFF");
      do_load(16'd10, 1'b1, "dec10");    scan_all("dec10");
      do_load(16'd10000, 1'b1, "dec10k"); scan_all("dec10k");
      do_load(16'h1000, 1'b0, "hex1000"); scan_all("hex1000");

      // randomized loads
      for (int n = 0; n < 16; n++) begin
         do_load(16'($urandom), 1'($urandom_range(0, 1)), "rnd");
         scan_all("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
